mgia_line_fetch: RTL

//  Bus-master sequencer that fills the MGIA ping-pong line buffers from framebuffer RAM.

---
 rtl/mgia_line_fetch.sv | 99 +++++++++
 1 files changed

// File: rtl/mgia_line_fetch.sv
// rtl/mgia_line_fetch.sv - MGIA scanline fetch sequencer: Wishbone read master filling ping-pong line buffers
module mgia_line_fetch #(
  parameter int WORDS_PER_LINE = 40,
  parameter int ADR_W          = 23
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             HSYNC_I,
  input  logic             VSYNC_I,
  input  logic             VEN_I,
  input  logic [ADR_W-1:0] FB_BASE_I,
  output logic [ADR_W-1:0] MGIA_ADR_O,
  output logic             MGIA_CYC_O,
  output logic             MGIA_STB_O,
  input  logic             MGIA_ACK_I,
  input  logic [15:0]      MGIA_DAT_I,
  output logic             ODD_O,
  output logic [5:0]       S_ADR_O,
  output logic [15:0]      S_DAT_O,
  output logic             S_WE_O,
  output logic             UNDERRUN_O
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [5:0]       LAST_WORD = 6'(WORDS_PER_LINE - 1);
  localparam logic [ADR_W-1:0] LINE_STEP = ADR_W'(WORDS_PER_LINE);

  state_t           state, state_next;
  logic [5:0]       count;
  logic [ADR_W-1:0] line_ptr;
  logic [ADR_W-1:0] ptr;
  logic             start;
  logic             store;

  // A VSYNC in the same cycle as HSYNC means the new line comes from the new frame base.
  assign ptr        = VSYNC_I ? FB_BASE_I : line_ptr;
  assign MGIA_CYC_O = (state == FETCH);
  assign MGIA_STB_O = (state == FETCH);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    store      = 1'b0;
    if (VSYNC_I || HSYNC_I) begin
      if (HSYNC_I && VEN_I) begin
        start      = 1'b1;
        state_next = FETCH;
      end else begin
        state_next = IDLE;
      end
    end else if (state == FETCH && MGIA_ACK_I) begin
      store = 1'b1;
      if (count == LAST_WORD) begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= IDLE;
      count      <= '0;
      line_ptr   <= '0;
      MGIA_ADR_O <= '0;
      ODD_O      <= 1'b0;
      S_ADR_O    <= '0;
      S_DAT_O    <= '0;
      S_WE_O     <= 1'b0;
      UNDERRUN_O <= 1'b0;
    end else begin
      state  <= state_next;
      S_WE_O <= store;

      if (VSYNC_I) begin
        line_ptr   <= FB_BASE_I;
        UNDERRUN_O <= 1'b0;
      end else if (HSYNC_I && state == FETCH) begin
        UNDERRUN_O <= 1'b1;
      end

      // line_ptr advances even if this line is later cut short, keeping frame geometry fixed.
      if (start) begin
        ODD_O      <= ~ODD_O;
        count      <= '0;
        MGIA_ADR_O <= ptr;
        line_ptr   <= ptr + LINE_STEP;
      end

      if (store) begin
        S_ADR_O    <= count;
        S_DAT_O    <= MGIA_DAT_I;
        count      <= count + 6'd1;
        MGIA_ADR_O <= MGIA_ADR_O + 1'b1;
      end
    end
  end

endmodule
